// File: rtl/load_store_unit.sv
//------------------------------------------------------------------------------
// Module   : load_store_unit
// Function : One-at-a-time RISC-V load/store initiator for a word-organised RAM
//            with sub-word read-modify-write, load extension and fault checks.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module load_store_unit #(
  parameter int HEIGHT = 64,
  parameter int LENGTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       reqValid_i,
  output logic                       reqReady_o,
  input  logic                       reqWrite_i,
  input  logic [2:0]                 funct3_i,
  input  logic [31:0]                addr_i,
  input  logic [LENGTH-1:0]          storeData_i,
  output logic                       respValid_o,
  output logic [LENGTH-1:0]          loadData_o,
  output logic                       fault_o,
  output logic [$clog2(HEIGHT)-1:0]  memAddress_o,
  output logic [LENGTH-1:0]          memDataOut_o,
  output logic                       memWriteEnable_o,
  input  logic [LENGTH-1:0]          memDataIn_i
);

  localparam int ADDR_W = $clog2(HEIGHT);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_q;
  logic                write_q;
  logic [2:0]          funct3_q;
  logic [1:0]          off_q;
  logic [15:0]         store_q;
  logic [ADDR_W-1:0]   memAddress_q;
  logic [LENGTH-1:0]   memDataOut_q;
  logic                memWriteEnable_q;
  logic                respValid_q;
  logic [LENGTH-1:0]   loadData_q;
  logic                fault_q;

  logic [29:0]         w_index;
  logic                w_range_fault;
  logic                w_align_fault;
  logic                w_f3_fault;
  logic                w_fault;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [LENGTH-1:0]   w_ext;
  logic [LENGTH-1:0]   w_merge;

  assign w_index       = addr_i[31:2];
  assign w_range_fault = ({2'b00, w_index} >= 32'(HEIGHT));
  assign w_align_fault = (((funct3_i == F3_H) || (funct3_i == F3_HU)) && addr_i[0]) ||
                         ((funct3_i == F3_W) && (addr_i[1:0] != 2'b00));
  assign w_f3_fault    = reqWrite_i
                       ? !((funct3_i == F3_B) || (funct3_i == F3_H) || (funct3_i == F3_W))
                       : ((funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111));
  assign w_fault       = w_range_fault || w_align_fault || w_f3_fault;

  // Little-endian lane selection from the word read during READ
  assign w_byte = memDataIn_i[8*off_q +: 8];
  assign w_half = memDataIn_i[16*off_q[1] +: 16];

  always_comb begin
    w_ext = memDataIn_i;
    case (funct3_q)
      F3_B:    w_ext = {{24{w_byte[7]}}, w_byte};
      F3_BU:   w_ext = {24'd0, w_byte};
      F3_H:    w_ext = {{16{w_half[15]}}, w_half};
      F3_HU:   w_ext = {16'd0, w_half};
      default: w_ext = memDataIn_i;
    endcase
  end

  always_comb begin
    w_merge = memDataIn_i;
    if (funct3_q == F3_B) begin
      w_merge[8*off_q +: 8] = store_q[7:0];
    end else if (funct3_q == F3_H) begin
      w_merge[16*off_q[1] +: 16] = store_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      write_q          <= 1'b0;
      funct3_q         <= 3'd0;
      off_q            <= 2'd0;
      store_q          <= 16'd0;
      memAddress_q     <= '0;
      memDataOut_q     <= '0;
      memWriteEnable_q <= 1'b0;
      respValid_q      <= 1'b0;
      loadData_q       <= '0;
      fault_q          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (reqValid_i) begin
            write_q      <= reqWrite_i;
            funct3_q     <= funct3_i;
            off_q        <= addr_i[1:0];
            store_q      <= storeData_i[15:0];
            memAddress_q <= addr_i[ADDR_W+1:2];
            loadData_q   <= '0;
            fault_q      <= w_fault;
            if (w_fault) begin
              respValid_q <= 1'b1;
              state_q     <= RESP;
            end else if (reqWrite_i && (funct3_i == F3_W)) begin
              memDataOut_q     <= storeData_i;
              memWriteEnable_q <= 1'b1;
              state_q          <= WRITE;
            end else begin
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (write_q) begin
            memDataOut_q     <= w_merge;
            memWriteEnable_q <= 1'b1;
            state_q          <= WRITE;
          end else begin
            loadData_q  <= w_ext;
            respValid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        WRITE: begin
          memWriteEnable_q <= 1'b0;
          respValid_q      <= 1'b1;
          state_q          <= RESP;
        end
        RESP: begin
          respValid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign reqReady_o       = (state_q == IDLE);
  assign respValid_o      = respValid_q;
  assign loadData_o       = loadData_q;
  assign fault_o          = fault_q;
  assign memAddress_o     = memAddress_q;
  assign memDataOut_o     = memDataOut_q;
  assign memWriteEnable_o = memWriteEnable_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_load_store_unit
// Function : Directed scoreboard bench for load_store_unit with a RAM model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;

  localparam int HEIGHT = 64;
  localparam int LENGTH = 32;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWrite = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] storeData = 32'd0;
  logic        respValid;
  logic [31:0] loadData;
  logic        fault;
  logic [5:0]  memAddress;
  logic [31:0] memDataOut;
  logic        memWriteEnable;
  logic [31:0] memDataIn;

  logic [31:0] mem [HEIGHT];
  exp_t        exp_q[$];
  int          acc_q[$];
  int          cyc = 0;
  int          we_cnt = 0;
  int          acc_cnt = 0;
  logic [5:0]  last_we_addr = '0;
  int          tests = 0;
  int          failed = 0;

  load_store_unit #(.HEIGHT(HEIGHT), .LENGTH(LENGTH)) dut (
    .clk(clk), .rst(rst),
    .reqValid_i(reqValid), .reqReady_o(reqReady), .reqWrite_i(reqWrite),
    .funct3_i(funct3), .addr_i(addr), .storeData_i(storeData),
    .respValid_o(respValid), .loadData_o(loadData), .fault_o(fault),
    .memAddress_o(memAddress), .memDataOut_o(memDataOut),
    .memWriteEnable_o(memWriteEnable), .memDataIn_i(memDataIn)
  );

  always #5 clk = ~clk;

  assign memDataIn = mem[memAddress];

  always @(posedge clk) begin
    if (memWriteEnable) begin
      mem[memAddress] <= memDataOut;
      we_cnt       = we_cnt + 1;
      last_we_addr = memAddress;
    end
    if (!rst && reqValid && reqReady) begin
      acc_q.push_back(cyc);
      acc_cnt = acc_cnt + 1;
    end
    cyc = cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      failed = failed + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every response is matched against the oldest expectation
  always @(negedge clk) begin
    if (!rst && respValid) begin
      chk("resp_expected", 32'(exp_q.size() > 0 && acc_q.size() > 0), 32'd1);
      chk("ready_in_resp", {31'd0, reqReady}, 32'd0);
      if (exp_q.size() > 0 && acc_q.size() > 0) begin
        exp_t e;
        int   a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("loadData", loadData, e.data);
        chk("fault", {31'd0, fault}, {31'd0, e.fault});
        chk("latency", 32'(cyc - a), 32'(e.lat));
      end
    end
  end

  task automatic req(input logic w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] ed, input logic ef,
                     input int lat);
    logic acc;
    exp_t e;
    e.data = ed; e.fault = ef; e.lat = lat;
    acc = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    reqValid = 1'b1; reqWrite = w; funct3 = f; addr = a; storeData = d;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = reqReady;
      @(posedge clk);
      if (!acc) @(negedge clk);
    end
    chk("accepted", {31'd0, acc}, 32'd1);
    @(negedge clk);
    reqValid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    if (exp_q.size() != 0) begin
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  initial begin
    int   we0;
    int   acc0;
    logic seen;
    logic [31:0] hw [4];
    logic [2:0]  hf [4];
    logic [31:0] ha [4];
    logic [31:0] hd [4];
    exp_t        he;

    for (int i = 0; i < HEIGHT; i++) mem[i] = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_reqReady", {31'd0, reqReady}, 32'd1);
    chk("rst_respValid", {31'd0, respValid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_loadData", loadData, 32'd0);
    chk("rst_memAddress", {26'd0, memAddress}, 32'd0);
    chk("rst_memDataOut", memDataOut, 32'd0);
    chk("rst_memWE", {31'd0, memWriteEnable}, 32'd0);
    rst = 1'b0;

    we0 = we_cnt;
    req(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    chk("sw_we_pulses", 32'(we_cnt - we0), 32'd1);
    chk("sw_we_addr", {26'd0, last_we_addr}, 32'd2);
    we0 = we_cnt;
    req(1'b0, 3'b010, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    chk("lw_no_we", 32'(we_cnt - we0), 32'd0);

    req(1'b1, 3'b000, 32'h9, 32'hFFFFFF55, 32'h0, 1'b0, 3);
    chk("sb_word", mem[2], 32'hDEAD55EF);
    req(1'b0, 3'b000, 32'h9, 32'h0, 32'h00000055, 1'b0, 2);
    req(1'b0, 3'b000, 32'hB, 32'h0, 32'hFFFFFFDE, 1'b0, 2);
    req(1'b0, 3'b100, 32'hB, 32'h0, 32'h000000DE, 1'b0, 2);

    req(1'b1, 3'b001, 32'hA, 32'h12348001, 32'h0, 1'b0, 3);
    chk("sh_word", mem[2], 32'h800155EF);
    req(1'b0, 3'b001, 32'hA, 32'h0, 32'hFFFF8001, 1'b0, 2);
    req(1'b0, 3'b101, 32'hA, 32'h0, 32'h00008001, 1'b0, 2);

    we0 = we_cnt;
    req(1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1'b1, 1);
    req(1'b0, 3'b001, 32'h3, 32'h0, 32'h0, 1'b1, 1);
    req(1'b1, 3'b010, 32'(4 * HEIGHT), 32'h12345678, 32'h0, 1'b1, 1);
    req(1'b0, 3'b011, 32'h8, 32'h0, 32'h0, 1'b1, 1);
    req(1'b1, 3'b100, 32'h8, 32'h12345678, 32'h0, 1'b1, 1);
    chk("fault_no_we", 32'(we_cnt - we0), 32'd0);
    chk("fault_word2", mem[2], 32'h800155EF);
    chk("fault_word0", mem[0], 32'h0);

    // Reset asserted in the middle of the SB write cycle
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; funct3 = 3'b000; addr = 32'h8; storeData = 32'h000000AA;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (memWriteEnable) seen = 1'b1;
      else @(negedge clk);
    end
    chk("rmw_reached_write", {31'd0, seen}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_we", {31'd0, memWriteEnable}, 32'd0);
    chk("arst_respValid", {31'd0, respValid}, 32'd0);
    chk("arst_reqReady", {31'd0, reqReady}, 32'd1);
    chk("arst_memAddress", {26'd0, memAddress}, 32'd0);
    chk("arst_memDataOut", memDataOut, 32'd0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_word2", mem[2], 32'h800155EF);
    req(1'b0, 3'b010, 32'h8, 32'h0, 32'h800155EF, 1'b0, 2);

    // reqValid held high across four back-to-back requests
    hw = '{32'd1, 32'd0, 32'd0, 32'd0};
    hf = '{3'b010, 3'b010, 3'b000, 3'b010};
    ha = '{32'h10, 32'h10, 32'h13, 32'h6};
    hd = '{32'h11223344, 32'h0, 32'h0, 32'h0};
    he.data = 32'h0;        he.fault = 1'b0; he.lat = 2; exp_q.push_back(he);
    he.data = 32'h11223344; he.fault = 1'b0; he.lat = 2; exp_q.push_back(he);
    he.data = 32'h00000011; he.fault = 1'b0; he.lat = 2; exp_q.push_back(he);
    he.data = 32'h0;        he.fault = 1'b1; he.lat = 1; exp_q.push_back(he);
    acc0 = acc_cnt;
    @(negedge clk);
    reqValid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic acc;
      acc = 1'b0;
      reqWrite = hw[k][0]; funct3 = hf[k]; addr = ha[k]; storeData = hd[k];
      for (int i = 0; i < 20 && !acc; i++) begin
        acc = reqReady;
        @(posedge clk);
        @(negedge clk);
      end
      chk("held_accept", {31'd0, acc}, 32'd1);
    end
    reqValid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    repeat (3) @(negedge clk);
    chk("held_drain", 32'(exp_q.size()), 32'd0);
    chk("held_accepts", 32'(acc_cnt - acc0), 32'd4);
    chk("held_word4", mem[4], 32'h11223344);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
